// File: rtl/bcd_counter_ctrl.sv
// Command-driven sequencer for an NDIG-digit BCD up/down counter.
// CLEAR/LOAD/STEP commands arrive over valid/ready; STEP advances the count by one per cycle.
module bcd_digit (
  input  logic [3:0] d,
  input  logic       cin,
  input  logic       down,
  output logic [3:0] y,
  output logic       cout
);
  always_comb begin
    y    = d;
    cout = 1'b0;
    if (cin) begin
      if (!down) begin
        if (d == 4'd9) begin
          y    = 4'd0;
          cout = 1'b1;
        end else begin
          y = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          y    = 4'd9;
          cout = 1'b1;
        end else begin
          y = d - 4'd1;
        end
      end
    end
  end
endmodule

module bcd_counter_ctrl #(
  parameter int NDIG  = 2,
  parameter int STEPW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [4*NDIG-1:0] cmd_arg,
  input  logic              abort,
  output logic [4*NDIG-1:0] q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wrap,
  output logic              ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;

  state_t            state, state_nxt;
  logic [STEPW-1:0]  remaining;
  logic              dir;
  logic              err_r;
  logic [4*NDIG-1:0] q_step;
  logic [NDIG:0]     carry;
  logic [NDIG-1:0]   dig_ok;
  logic              accept;

  // carry[0] forced high: the chain always steps by one; carry out of the top digit is the wrap
  assign carry[0] = 1'b1;

  generate
    for (genvar g = 0; g < NDIG; g++) begin : g_dig
      bcd_digit u_dig (
        .d    (q[4*g +: 4]),
        .cin  (carry[g]),
        .down (dir),
        .y    (q_step[4*g +: 4]),
        .cout (carry[g+1])
      );
      assign dig_ok[g] = (cmd_arg[4*g +: 4] <= 4'd9);
    end
  endgenerate

  assign accept    = cmd_valid && (state == IDLE);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign err       = (state == DONE) && err_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_op[1] && (cmd_arg[STEPW-1:0] != '0)) state_nxt = RUN;
          else                                         state_nxt = DONE;
        end
      end
      RUN: begin
        if (abort || (remaining == STEPW'(1))) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      q         <= '0;
      remaining <= '0;
      dir       <= 1'b0;
      err_r     <= 1'b0;
      wrap      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state <= state_nxt;
      wrap  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            err_r <= 1'b0;
            case (cmd_op)
              OP_CLEAR: begin
                q   <= '0;
                ovf <= 1'b0;
              end
              OP_LOAD: begin
                if (&dig_ok) q     <= cmd_arg;
                else         err_r <= 1'b1;
              end
              default: begin
                remaining <= cmd_arg[STEPW-1:0];
                dir       <= cmd_op[0];
              end
            endcase
          end
        end
        RUN: begin
          if (!abort) begin
            q         <= q_step;
            remaining <= remaining - STEPW'(1);
            wrap      <= carry[NDIG];
            if (carry[NDIG]) ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Scoreboard bench for bcd_counter_ctrl: stimulus queues hand-computed step/done results,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_bcd_counter_ctrl;
  localparam int NDIG  = 2;
  localparam int STEPW = 8;
  localparam logic [1:0] CLR = 2'b00, LD = 2'b01, UP = 2'b10, DN = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_arg = 8'h00;
  logic       abort = 1'b0;
  logic [7:0] q;
  logic       busy, done, err, wrap, ovf;

  typedef struct packed { logic [7:0] q; logic wrap; } step_t;
  typedef struct packed { logic [7:0] q; logic err; logic ovf; } done_t;

  step_t step_q[$];
  done_t done_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int done_exp = 0;
  logic prev_busy = 1'b0;

  bcd_counter_ctrl #(.NDIG(NDIG), .STEPW(STEPW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .q(q), .busy(busy),
    .done(done), .err(err), .wrap(wrap), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a cycle that followed a busy cycle carries one RUN-edge result; a done cycle carries the completion.
  always @(negedge clk) begin
    if (reset) begin
      prev_busy <= 1'b0;
    end else begin
      if (prev_busy) begin
        if (step_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL step_unexpected: q=%h wrap=%b with nothing expected", q, wrap);
        end else begin
          step_t e;
          e = step_q.pop_front();
          check("step_q", q, e.q);
          check("step_wrap", {7'd0, wrap}, {7'd0, e.wrap});
        end
      end
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_unexpected: q=%h err=%b", q, err);
        end else begin
          done_t d;
          d = done_q.pop_front();
          check("done_q", q, d.q);
          check("done_err", {7'd0, err}, {7'd0, d.err});
          check("done_ovf", {7'd0, ovf}, {7'd0, d.ovf});
          check("done_busy", {7'd0, busy}, 8'd0);
        end
      end
      prev_busy <= busy;
    end
  end

  task automatic exp_step(input logic [7:0] v, input logic w);
    step_q.push_back('{q: v, wrap: w});
  endtask

  task automatic exp_done(input logic [7:0] v, input logic e, input logic o);
    done_q.push_back('{q: v, err: e, ovf: o});
    done_exp++;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  // Drive a command and return just after its accept edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] arg);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd();
    @(negedge clk);
    wait_ready();
  endtask

  initial begin
    #12;
    check("rst_q", q, 8'h00);
    check("rst_flags", {3'd0, busy, done, err, wrap, ovf}, 8'h00);
    @(negedge clk); reset = 1'b0;
    check("rst_ready", {7'd0, cmd_ready}, 8'd1);

    // Reset mid-RUN
    for (int i = 1; i <= 5; i++) exp_step(8'(i), 1'b0);
    issue(UP, 8'd20);
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    check("midrst_q", q, 8'h00);
    check("midrst_flags", {3'd0, busy, done, err, wrap, ovf}, 8'h00);
    check("midrst_queue", 8'(step_q.size()), 8'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", {7'd0, cmd_ready}, 8'd1);

    // LOAD 37, STEP_UP 5
    exp_done(8'h37, 1'b0, 1'b0);
    issue(LD, 8'h37); finish_cmd();
    exp_step(8'h38, 0); exp_step(8'h39, 0); exp_step(8'h40, 0);
    exp_step(8'h41, 0); exp_step(8'h42, 0);
    exp_done(8'h42, 1'b0, 1'b0);
    issue(UP, 8'd5); finish_cmd();

    // Up-wrap through 99, then CLEAR
    exp_done(8'h98, 1'b0, 1'b0);
    issue(LD, 8'h98); finish_cmd();
    exp_step(8'h99, 0); exp_step(8'h00, 1); exp_step(8'h01, 0);
    exp_done(8'h01, 1'b0, 1'b1);
    issue(UP, 8'd3); finish_cmd();
    exp_done(8'h00, 1'b0, 1'b0);
    issue(CLR, 8'h00); finish_cmd();

    // Down-wrap, then zero-length step
    exp_done(8'h01, 1'b0, 1'b0);
    issue(LD, 8'h01); finish_cmd();
    exp_step(8'h00, 0); exp_step(8'h99, 1);
    exp_done(8'h99, 1'b0, 1'b1);
    issue(DN, 8'd2); finish_cmd();
    exp_done(8'h99, 1'b0, 1'b1);
    issue(UP, 8'd0); finish_cmd();

    // Invalid LOAD, then abort after four steps (upper cmd_arg bits beyond STEPW are irrelevant here)
    exp_done(8'h99, 1'b1, 1'b1);
    issue(LD, 8'h5A); finish_cmd();
    exp_step(8'h00, 1); exp_step(8'h01, 0); exp_step(8'h02, 0); exp_step(8'h03, 0);
    exp_step(8'h03, 0);
    exp_done(8'h03, 1'b0, 1'b1);
    issue(UP, 8'd10);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    finish_cmd();
    exp_done(8'h00, 1'b0, 1'b0);
    issue(CLR, 8'h00); finish_cmd();

    // cmd_valid held through RUN/DONE with a pending LOAD
    exp_step(8'h01, 0); exp_step(8'h02, 0); exp_step(8'h03, 0);
    exp_done(8'h03, 1'b0, 1'b0);
    exp_done(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = UP; cmd_arg = 8'd3;
    wait_ready();
    @(posedge clk); #1;
    cmd_op = LD; cmd_arg = 8'h55;
    @(negedge clk);
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    finish_cmd();
    repeat (4) @(negedge clk);
    check("held_q", q, 8'h55);
    check("done_count", 8'(done_seen), 8'(done_exp));
    check("step_left", 8'(step_q.size()), 8'd0);
    check("done_left", 8'(done_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
